lsu_mem_port: RTL and testbench
===============================

LSU_MEM_PORT -- requirements
Module: lsu_mem_port

Interface
REQ-001 Parameter WB_DEPTH, default 4: number of write-buffer entries; SHALL be a power of two, at least 2.
REQ-002 Parameter SRAM_AW, default 12: SRAM word-address width; the port SHALL use address bits [SRAM_AW-1:0] and ignore the upper bits.
REQ-003 clk  in  1: clock; rst  in  1: reset, synchronous, active-high.
REQ-004 IN_re  in  1: read request, active-low; IN_readAddr  in  30: read word address.
REQ-005 IN_we  in  1: write request, active-low; IN_writeAddr  in  30: write word address; IN_writeData  in  32: write data; IN_wm  in  4: byte enables, active-high, bit n covers byte n.
REQ-006 OUT_readData  out  32: read result, valid exactly one cycle after the accepted IN_re.
REQ-007 OUT_wbFull  out  1: write buffer holds WB_DEPTH entries; OUT_overflow  out  1: sticky write-dropped flag.
REQ-008 OUT_SRAM_ce  out  1 (active-low); OUT_SRAM_we  out  1 (active-low); OUT_SRAM_addr  out  SRAM_AW; OUT_SRAM_wdata  out  32; OUT_SRAM_wm  out  4; IN_SRAM_rdata  in  32, returned one cycle after a read.

Function
REQ-009 The block SHALL respond to the LSU memory port with a fixed 1-cycle read latency and SHALL have no read stall.
REQ-010 The single-port SRAM SHALL do at most one access per cycle; a read SHALL have priority over a write-buffer drain.
REQ-011 Accepted writes SHALL go into a FIFO write buffer (address, data, mask); SRAM writes SHALL only come from a head drain.
REQ-012 Drain: in any cycle with IN_re high and a non-empty buffer, the head SHALL be written (OUT_SRAM_we=0, OUT_SRAM_wm=entry mask) and popped at the clock edge.
REQ-013 A write and a drain in the same cycle SHALL leave the occupancy unchanged; head and tail pointers SHALL wrap modulo WB_DEPTH.
REQ-014 Forwarding: on a read, each byte SHALL come from the youngest buffered entry with a matching address and that byte enabled, else from IN_SRAM_rdata.
REQ-015 A write accepted in the same cycle as a read to the same address SHALL be the youngest source for the forward.
REQ-016 The forward mask and data SHALL be registered at the read cycle and merged with IN_SRAM_rdata in the following cycle.
REQ-017 OUT_readData SHALL be 0 in any cycle not following an accepted read.
REQ-018 OUT_wbFull SHALL be registered, equal to (occupancy == WB_DEPTH). Upstream SHALL NOT issue writes while it is high.
REQ-019 A write presented while OUT_wbFull is high SHALL be dropped and SHALL set OUT_overflow, which stays set until rst.
REQ-020 A write with IN_wm == 0 SHALL be accepted and SHALL NOT allocate an entry.

Reset
REQ-021 rst SHALL empty the buffer and discard pending writes; OUT_wbFull=0, OUT_overflow=0, OUT_readData=0, OUT_SRAM_ce=1, OUT_SRAM_we=1.
REQ-022 A read accepted in the cycle rst is asserted SHALL NOT produce data; OUT_readData SHALL be 0 in the next cycle.

Configuration
REQ-023 Macro LSU_WB_COALESCE_EN defined: a write whose address matches the youngest valid entry, where that entry is not being drained this cycle, SHALL merge into that entry bytewise under IN_wm and SHALL NOT allocate.
REQ-024 Macro LSU_WB_COALESCE_EN undefined: every write with a non-zero mask SHALL allocate a new entry.

Structure
REQ-025 Package lsu_mem_pkg SHALL hold the write-buffer entry struct (addr, data, mask, valid) and the default WB_DEPTH and SRAM_AW constants.
REQ-026 The byte-forwarding priority search SHALL be one combinational sub-module, lsu_wb_fwd.

Verification
REQ-027 Write 0x11223344, mask 1111, to address 0x10, then read 0x10 on the next cycle before any drain -> OUT_readData=0x11223344 one cycle later.
REQ-028 Write mask 0011 to 0x20; SRAM already holds 0xAABBCCDD at 0x20; write data 0x00005566; then read 0x20 -> 0xAABB5566.
REQ-029 Four writes with no reads (WB_DEPTH=4) -> drains start on the first idle cycle, and the SRAM receives the writes in order.
REQ-030 Hold IN_re low every cycle and issue four writes -> OUT_wbFull=1; a fifth write -> dropped, OUT_overflow=1.
REQ-031 Read with a same-cycle write to the same address, data 0xDEADBEEF, mask 1111 -> OUT_readData=0xDEADBEEF.
REQ-032 Assert rst with three buffered writes -> after rst, no SRAM writes occur, and a read of those addresses returns the original SRAM contents.

Source files
------------

// File: rtl/lsu_mem_pkg.sv
// ============================================================================
//  Module      : lsu_mem_pkg
//  Description : Shared types and defaults for the LSU memory port: the
//                write-buffer entry layout, default sizing constants and a
//                bytewise merge helper.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lsu_mem_pkg;

    localparam int unsigned c_WB_DEPTH = 4;   // default write-buffer entries
    localparam int unsigned c_SRAM_AW  = 12;  // default SRAM word-address width
    localparam int unsigned c_WORD_AW  = 30;  // LSU word-address width

    // One buffered write. addr holds the word address already truncated
    // to the SRAM address width (upper bits forced to zero).
    typedef struct packed {
        logic [c_WORD_AW-1:0] addr;
        logic [31:0]          data;
        logic [3:0]           mask;
        logic                 valid;
    } wb_entry_t;

    // Replace the bytes of old_d selected by m with the bytes of new_d.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_d,
                                               input logic [31:0] new_d,
                                               input logic [3:0]  m);
        logic [31:0] r;
        r = old_d;
        for (int b = 0; b < 4; b++) begin
            if (m[b]) r[b*8 +: 8] = new_d[b*8 +: 8];
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_wb_fwd.sv
// ============================================================================
//  Module      : lsu_wb_fwd
//  Description : Combinational byte-forwarding search. Walks the write buffer
//                from oldest to youngest so that younger hits overwrite older
//                ones, then lets the write accepted this cycle win over all.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_wb_fwd
    import lsu_mem_pkg::*;
#(
    parameter int unsigned WB_DEPTH = c_WB_DEPTH,
    parameter int unsigned PW       = $clog2(c_WB_DEPTH)
) (
    input  wb_entry_t [WB_DEPTH-1:0] entries_i,
    input  logic [PW-1:0]            head_i,
    input  logic [c_WORD_AW-1:0]     raddr_i,
    input  logic                     new_vld_i,
    input  logic [c_WORD_AW-1:0]     new_addr_i,
    input  logic [31:0]              new_data_i,
    input  logic [3:0]               new_mask_i,
    output logic [3:0]               fwd_mask_o,
    output logic [31:0]              fwd_data_o
);

    logic [PW-1:0] idx;

    // Age-ordered priority search: later (younger) matches overwrite earlier.
    always_comb begin
        fwd_mask_o = 4'b0000;
        fwd_data_o = 32'h0;
        idx        = head_i;
        for (int k = 0; k < int'(WB_DEPTH); k++) begin
            idx = head_i + PW'(k);
            if (entries_i[idx].valid && (entries_i[idx].addr == raddr_i)) begin
                fwd_data_o = byte_merge(fwd_data_o, entries_i[idx].data, entries_i[idx].mask);
                fwd_mask_o = fwd_mask_o | entries_i[idx].mask;
            end
        end
        if (new_vld_i && (new_addr_i == raddr_i)) begin
            fwd_data_o = byte_merge(fwd_data_o, new_data_i, new_mask_i);
            fwd_mask_o = fwd_mask_o | new_mask_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/lsu_mem_port.sv
// ============================================================================
//  Module      : lsu_mem_port
//  Description : LSU-to-single-port-SRAM adapter. Reads have a fixed 1-cycle
//                latency and never stall; writes are queued in a FIFO write
//                buffer that drains to the SRAM in cycles without a read.
//                Reads see buffered data through bytewise forwarding.
//  Config      : LSU_WB_COALESCE_EN - when defined, a write to the address of
//                the youngest buffered entry merges into it instead of
//                allocating a new entry.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_mem_port
    import lsu_mem_pkg::*;
#(
    parameter int unsigned WB_DEPTH = c_WB_DEPTH,  // power of two, >= 2
    parameter int unsigned SRAM_AW  = c_SRAM_AW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 IN_re,
    input  logic [29:0]          IN_readAddr,
    input  logic                 IN_we,
    input  logic [29:0]          IN_writeAddr,
    input  logic [31:0]          IN_writeData,
    input  logic [3:0]           IN_wm,
    output logic [31:0]          OUT_readData,
    output logic                 OUT_wbFull,
    output logic                 OUT_overflow,
    output logic                 OUT_SRAM_ce,
    output logic                 OUT_SRAM_we,
    output logic [SRAM_AW-1:0]   OUT_SRAM_addr,
    output logic [31:0]          OUT_SRAM_wdata,
    output logic [3:0]           OUT_SRAM_wm,
    input  logic [31:0]          IN_SRAM_rdata
);

    localparam int unsigned     PW          = $clog2(WB_DEPTH);
    localparam logic [PW:0]     c_FULL      = (PW+1)'(WB_DEPTH);
    localparam logic [29:0]     c_ADDR_MASK = 30'((64'(1) << SRAM_AW) - 64'(1));

    wb_entry_t [WB_DEPTH-1:0] wb_q;
    logic [PW-1:0] head_q, tail_q;
    logic [PW:0]   count_q, count_d;
    logic          full_q, full_d;
    logic          ovf_q, ovf_d;
    logic          rd_vld_q;
    logic [3:0]    fwd_mask, fwd_mask_q;
    logic [31:0]   fwd_data, fwd_data_q;

    logic [29:0]   rd_addr, wr_addr;
    logic          rd_req, wr_req, wr_acc, wr_nz, drain, coalesce, alloc;

`ifdef LSU_WB_COALESCE_EN
    logic [PW-1:0] yidx;
`endif

    // Request decode, drain/allocation decisions and next occupancy.
    always_comb begin
        rd_addr  = IN_readAddr & c_ADDR_MASK;
        wr_addr  = IN_writeAddr & c_ADDR_MASK;
        rd_req   = ~rst & ~IN_re;
        wr_req   = ~rst & ~IN_we;
        wr_acc   = wr_req & ~full_q;
        wr_nz    = wr_acc & (IN_wm != 4'b0000);
        drain    = ~rst & IN_re & (count_q != '0);
`ifdef LSU_WB_COALESCE_EN
        yidx     = tail_q - PW'(1);
        // The youngest entry is only the drained head when it is the sole entry.
        coalesce = wr_nz & wb_q[yidx].valid & (wb_q[yidx].addr == wr_addr)
                 & ~(drain & (yidx == head_q));
`else
        coalesce = 1'b0;
`endif
        alloc    = wr_nz & ~coalesce;
        count_d  = count_q + (PW+1)'(alloc) - (PW+1)'(drain);
        full_d   = (count_d == c_FULL);
        ovf_d    = ovf_q | (wr_req & full_q);
    end

    lsu_wb_fwd #(
        .WB_DEPTH (WB_DEPTH),
        .PW       (PW)
    ) u_fwd (
        .entries_i  (wb_q),
        .head_i     (head_q),
        .raddr_i    (rd_addr),
        .new_vld_i  (wr_nz),
        .new_addr_i (wr_addr),
        .new_data_i (IN_writeData),
        .new_mask_i (IN_wm),
        .fwd_mask_o (fwd_mask),
        .fwd_data_o (fwd_data)
    );

    // Buffer pointers, entries, status flags and the read-side forward stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_q       <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            ovf_q      <= 1'b0;
            rd_vld_q   <= 1'b0;
            fwd_mask_q <= 4'b0000;
            fwd_data_q <= 32'h0;
        end else begin
            head_q     <= head_q + PW'(drain);
            tail_q     <= tail_q + PW'(alloc);
            count_q    <= count_d;
            full_q     <= full_d;
            ovf_q      <= ovf_d;
            rd_vld_q   <= rd_req;
            fwd_mask_q <= fwd_mask;
            fwd_data_q <= fwd_data;
            if (drain) begin
                wb_q[head_q].valid <= 1'b0;
            end
            if (alloc) begin
                wb_q[tail_q] <= '{addr: wr_addr, data: IN_writeData, mask: IN_wm, valid: 1'b1};
            end
`ifdef LSU_WB_COALESCE_EN
            if (coalesce) begin
                wb_q[yidx].data <= byte_merge(wb_q[yidx].data, IN_writeData, IN_wm);
                wb_q[yidx].mask <= wb_q[yidx].mask | IN_wm;
            end
`endif
        end
    end

    // A read owns the SRAM; otherwise the buffer head drains.
    assign OUT_SRAM_ce    = ~(rd_req | drain);
    assign OUT_SRAM_we    = ~drain;
    assign OUT_SRAM_addr  = drain ? wb_q[head_q].addr[SRAM_AW-1:0] : IN_readAddr[SRAM_AW-1:0];
    assign OUT_SRAM_wdata = drain ? wb_q[head_q].data : 32'h0;
    assign OUT_SRAM_wm    = drain ? wb_q[head_q].mask : 4'b0000;

    assign OUT_readData   = rd_vld_q ? byte_merge(IN_SRAM_rdata, fwd_data_q, fwd_mask_q) : 32'h0;
    assign OUT_wbFull     = full_q;
    assign OUT_overflow   = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_lsu_mem_port.sv
// ============================================================================
//  Module      : tb_lsu_mem_port
//  Description : Directed self-checking bench for lsu_mem_port with a
//                behavioural single-port SRAM and an SRAM write log.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu_mem_port;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        IN_re = 1'b1;
    logic [29:0] IN_readAddr = '0;
    logic        IN_we = 1'b1;
    logic [29:0] IN_writeAddr = '0;
    logic [31:0] IN_writeData = '0;
    logic [3:0]  IN_wm = '0;
    logic [31:0] OUT_readData;
    logic        OUT_wbFull, OUT_overflow;
    logic        OUT_SRAM_ce, OUT_SRAM_we;
    logic [11:0] OUT_SRAM_addr;
    logic [31:0] OUT_SRAM_wdata;
    logic [3:0]  OUT_SRAM_wm;
    logic [31:0] sram_rdata = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lsu_mem_port #(.WB_DEPTH(4), .SRAM_AW(12)) dut (
        .clk(clk), .rst(rst),
        .IN_re(IN_re), .IN_readAddr(IN_readAddr),
        .IN_we(IN_we), .IN_writeAddr(IN_writeAddr), .IN_writeData(IN_writeData), .IN_wm(IN_wm),
        .OUT_readData(OUT_readData), .OUT_wbFull(OUT_wbFull), .OUT_overflow(OUT_overflow),
        .OUT_SRAM_ce(OUT_SRAM_ce), .OUT_SRAM_we(OUT_SRAM_we), .OUT_SRAM_addr(OUT_SRAM_addr),
        .OUT_SRAM_wdata(OUT_SRAM_wdata), .OUT_SRAM_wm(OUT_SRAM_wm), .IN_SRAM_rdata(sram_rdata)
    );

    // Behavioural SRAM with backdoor preload and a log of every write.
    logic [31:0] mem [0:4095];
    logic        pre_en = 1'b0;
    logic [11:0] pre_addr = '0;
    logic [31:0] pre_data = '0;
    logic [11:0] log_addr [$];
    logic [31:0] log_data [$];
    logic [3:0]  log_wm   [$];

    always @(posedge clk) begin
        if (pre_en) mem[pre_addr] <= pre_data;
        if (!OUT_SRAM_ce) begin
            if (!OUT_SRAM_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (OUT_SRAM_wm[b]) mem[OUT_SRAM_addr][b*8 +: 8] <= OUT_SRAM_wdata[b*8 +: 8];
                end
                log_addr.push_back(OUT_SRAM_addr);
                log_data.push_back(OUT_SRAM_wdata);
                log_wm.push_back(OUT_SRAM_wm);
            end else begin
                sram_rdata <= mem[OUT_SRAM_addr];
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        IN_re = 1'b1;
        IN_we = 1'b1;
        repeat (n) step();
    endtask

    task automatic wr(input logic [29:0] a, input logic [31:0] d, input logic [3:0] m);
        IN_we = 1'b0; IN_writeAddr = a; IN_writeData = d; IN_wm = m;
    endtask

    task automatic rd(input logic [29:0] a);
        IN_re = 1'b0; IN_readAddr = a;
    endtask

    task automatic preload(input logic [11:0] a, input logic [31:0] d);
        pre_addr = a; pre_data = d; pre_en = 1'b1;
        step();
        pre_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rd(30'h10);
        wr(30'h10, 32'hFFFFFFFF, 4'hF);
        step();
        checks++; if (OUT_SRAM_ce !== 1'b1) begin errors++; $display("FAIL rst_ce got %b expected 1", OUT_SRAM_ce); end
        checks++; if (OUT_SRAM_we !== 1'b1) begin errors++; $display("FAIL rst_we got %b expected 1", OUT_SRAM_we); end
        checks++; if (OUT_wbFull !== 1'b0) begin errors++; $display("FAIL rst_full got %b expected 0", OUT_wbFull); end
        checks++; if (OUT_overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b expected 0", OUT_overflow); end
        rst = 1'b0;
        idle(1);
        checks++; if (OUT_readData !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h expected 0", OUT_readData); end
        checks++; if (OUT_SRAM_ce !== 1'b1) begin errors++; $display("FAIL idle_ce got %b expected 1", OUT_SRAM_ce); end
        idle(2);
    endtask

    task automatic test_forward_full();
        wr(30'h10, 32'h11223344, 4'hF);
        step();
        IN_we = 1'b1;
        rd(30'h10);
        step();
        IN_re = 1'b1;
        checks++; if (OUT_readData !== 32'h11223344) begin errors++; $display("FAIL fwd_full got %h expected 11223344", OUT_readData); end
        idle(4);
        checks++; if (OUT_readData !== 32'h0) begin errors++; $display("FAIL rdata_idle got %h expected 0", OUT_readData); end
        checks++; if (mem[12'h10] !== 32'h11223344) begin errors++; $display("FAIL drain_10 got %h expected 11223344", mem[12'h10]); end
    endtask

    task automatic test_partial();
        wr(30'h20, 32'h00005566, 4'b0011);
        step();
        IN_we = 1'b1;
        rd(30'h20);
        step();
        IN_re = 1'b1;
        checks++; if (OUT_readData !== 32'hAABB5566) begin errors++; $display("FAIL fwd_partial got %h expected aabb5566", OUT_readData); end
        idle(4);
        checks++; if (mem[12'h20] !== 32'hAABB5566) begin errors++; $display("FAIL drain_20 got %h expected aabb5566", mem[12'h20]); end
    endtask

    task automatic test_drain_order();
        int n0;
        n0 = log_addr.size();
        for (int i = 0; i < 4; i++) begin
            wr(30'h40 + 30'(i), 32'hC0DE0000 + 32'(i), 4'hF);
            step();
        end
        idle(6);
        checks++; if (log_addr.size() - n0 !== 4) begin errors++; $display("FAIL order_count got %0d expected 4", log_addr.size() - n0); end
        if (log_addr.size() - n0 >= 4) begin
            for (int i = 0; i < 4; i++) begin
                checks++; if (log_addr[n0+i] !== 12'h40 + 12'(i)) begin errors++; $display("FAIL order_addr%0d got %h expected %h", i, log_addr[n0+i], 12'h40 + 12'(i)); end
                checks++; if (log_data[n0+i] !== 32'hC0DE0000 + 32'(i)) begin errors++; $display("FAIL order_data%0d got %h expected %h", i, log_data[n0+i], 32'hC0DE0000 + 32'(i)); end
            end
            checks++; if (log_wm[n0] !== 4'hF) begin errors++; $display("FAIL order_wm got %h expected f", log_wm[n0]); end
        end
    endtask

    task automatic test_full_overflow();
        int n0;
        n0 = log_addr.size();
        for (int i = 0; i < 4; i++) begin
            rd(30'h0);
            wr(30'h50 + 30'(i), 32'h50500000 + 32'(i), 4'hF);
            step();
            if (i == 2) begin
                checks++; if (OUT_wbFull !== 1'b0) begin errors++; $display("FAIL full_at3 got %b expected 0", OUT_wbFull); end
            end
        end
        checks++; if (OUT_wbFull !== 1'b1) begin errors++; $display("FAIL full_at4 got %b expected 1", OUT_wbFull); end
        checks++; if (OUT_overflow !== 1'b0) begin errors++; $display("FAIL ovf_at4 got %b expected 0", OUT_overflow); end
        wr(30'h54, 32'h54545454, 4'hF);
        step();
        checks++; if (OUT_overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b expected 1", OUT_overflow); end
        checks++; if (OUT_wbFull !== 1'b1) begin errors++; $display("FAIL full_hold got %b expected 1", OUT_wbFull); end
        idle(1);
        checks++; if (OUT_wbFull !== 1'b0) begin errors++; $display("FAIL full_clear got %b expected 0", OUT_wbFull); end
        idle(5);
        checks++; if (log_addr.size() - n0 !== 4) begin errors++; $display("FAIL ovf_count got %0d expected 4", log_addr.size() - n0); end
        if (log_addr.size() - n0 >= 4) begin
            checks++; if (log_addr[n0+3] !== 12'h53) begin errors++; $display("FAIL ovf_last got %h expected 53", log_addr[n0+3]); end
        end
        checks++; if (mem[12'h54] !== 32'h0) begin errors++; $display("FAIL dropped_54 got %h expected 0", mem[12'h54]); end
        checks++; if (OUT_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b expected 1", OUT_overflow); end
    endtask

    task automatic test_same_cycle();
        rd(30'h60);
        wr(30'h60, 32'hDEADBEEF, 4'hF);
        step();
        IN_re = 1'b1; IN_we = 1'b1;
        checks++; if (OUT_readData !== 32'hDEADBEEF) begin errors++; $display("FAIL same_cycle got %h expected deadbeef", OUT_readData); end
        idle(3);
        // Priority: same-cycle write > younger entry > older entry > SRAM.
        rd(30'h0); wr(30'h70, 32'h00AAAAAA, 4'b0111); step();
        rd(30'h0); wr(30'h70, 32'h00CC0000, 4'b0100); step();
        rd(30'h70); wr(30'h70, 32'h000000DD, 4'b0001); step();
        IN_re = 1'b1; IN_we = 1'b1;
        checks++; if (OUT_readData !== 32'h55CCAADD) begin errors++; $display("FAIL youngest got %h expected 55ccaadd", OUT_readData); end
        idle(5);
        checks++; if (mem[12'h70] !== 32'h55CCAADD) begin errors++; $display("FAIL drain_70 got %h expected 55ccaadd", mem[12'h70]); end
    endtask

    task automatic test_wm_zero();
        int n0;
        n0 = log_addr.size();
        wr(30'h90, 32'hFFFFFFFF, 4'h0);
        step();
        idle(3);
        checks++; if (log_addr.size() !== n0) begin errors++; $display("FAIL wm0_alloc got %0d writes expected 0", log_addr.size() - n0); end
        checks++; if (OUT_wbFull !== 1'b0) begin errors++; $display("FAIL wm0_full got %b expected 0", OUT_wbFull); end
    endtask

    task automatic test_reset_flush();
        int n0;
        logic [31:0] exp_d;
        n0 = log_addr.size();
        for (int i = 0; i < 3; i++) begin
            rd(30'h0);
            wr(30'h80 + 30'(i), 32'hFFFF0000 + 32'(i), 4'hF);
            step();
        end
        IN_we = 1'b1;
        rst = 1'b1;
        rd(30'h80);
        step();
        rst = 1'b0;
        IN_re = 1'b1;
        checks++; if (OUT_readData !== 32'h0) begin errors++; $display("FAIL rst_read got %h expected 0", OUT_readData); end
        checks++; if (OUT_overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf_clr got %b expected 0", OUT_overflow); end
        idle(4);
        checks++; if (log_addr.size() !== n0) begin errors++; $display("FAIL flush_writes got %0d expected 0", log_addr.size() - n0); end
        for (int i = 0; i < 3; i++) begin
            exp_d = {4{8'h80 + 8'(i)}};
            rd(30'h80 + 30'(i));
            step();
            IN_re = 1'b1;
            checks++; if (OUT_readData !== exp_d) begin errors++; $display("FAIL flush_read%0d got %h expected %h", i, OUT_readData, exp_d); end
        end
    endtask

    initial begin
        rst = 1'b1;
        preload(12'h10, 32'h0);
        preload(12'h20, 32'hAABBCCDD);
        preload(12'h54, 32'h0);
        preload(12'h60, 32'h01020304);
        preload(12'h70, 32'h55667788);
        preload(12'h80, 32'h80808080);
        preload(12'h81, 32'h81818181);
        preload(12'h82, 32'h82828282);
        test_reset();
        test_forward_full();
        test_partial();
        test_drain_order();
        test_full_overflow();
        test_same_cycle();
        test_wm_zero();
        test_reset_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
